// File: rtl/a2d_intf_if.sv
// rtl/a2d_intf_if.sv - conversion handshake and SPI pins between motion_cntrl, a2d_intf and the converter
interface a2d_intf_if;
    logic        start_conv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  start_conv, chnnl, MISO,
        output cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
    );

    modport slave (
        output start_conv, chnnl, MISO,
        input  cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - SPI master running a command frame and a result frame per 12-bit A2D conversion
module a2d_intf #(
    parameter int DEAD_CYC = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    a2d_intf_if.master   bus
);
    typedef enum logic [1:0] {IDLE, TX1, DEAD, TX2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  sclk_div_q, sclk_div_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic [11:0] rx_shift_q, rx_shift_d;
    logic [4:0]  rise_cnt_q, rise_cnt_d;
    logic        first_fall_q, first_fall_d;
    logic [7:0]  dead_cnt_q, dead_cnt_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic        ss_n_q, ss_n_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;
    logic [11:0] a2d_res_q, a2d_res_d;
    logic        enter_frame;
    logic        sclk_rise;
    logic        sclk_wrap;

    assign sclk_rise = (sclk_div_q == 5'd15);
    assign sclk_wrap = (sclk_div_q == 5'd31);

    always_comb begin
        state_d      = state_q;
        sclk_div_d   = sclk_div_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rise_cnt_d   = rise_cnt_q;
        first_fall_d = first_fall_q;
        dead_cnt_d   = dead_cnt_q;
        chnnl_d      = chnnl_q;
        ss_n_d       = ss_n_q;
        cnv_cmplt_d  = cnv_cmplt_q;
        a2d_res_d    = a2d_res_q;
        enter_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_conv) begin
                    state_d     = TX1;
                    chnnl_d     = bus.chnnl;
                    cnv_cmplt_d = 1'b0;
                    enter_frame = 1'b1;
                end
            end
            TX1, TX2: begin
                // Frame ends on the wrap after the 16th rise; the divider stays at 31 so SCLK idles high
                if (sclk_wrap && (rise_cnt_q == 5'd16)) begin
                    ss_n_d = 1'b1;
                    if (state_q == TX1) begin
                        state_d    = DEAD;
                        dead_cnt_d = 8'd0;
                    end else begin
                        state_d     = IDLE;
                        a2d_res_d   = rx_shift_q;
                        cnv_cmplt_d = 1'b1;
                    end
                end else begin
                    sclk_div_d = sclk_div_q + 5'd1;
                    if (sclk_rise) begin
                        // Only the last 12 bits survive; the upper nibble shifts out the top
                        rx_shift_d = {rx_shift_q[10:0], bus.MISO};
                        rise_cnt_d = rise_cnt_q + 5'd1;
                    end
                    if (sclk_wrap) begin
                        first_fall_d = 1'b0;
                        if (!first_fall_q) begin
                            tx_shift_d = {tx_shift_q[14:0], 1'b0};
                        end
                    end
                end
            end
            DEAD: begin
                dead_cnt_d = dead_cnt_q + 8'd1;
                if (dead_cnt_q == 8'(DEAD_CYC - 1)) begin
                    state_d     = TX2;
                    enter_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Both frames carry the same command word so the converter stays on the latched channel
        if (enter_frame) begin
            ss_n_d       = 1'b0;
            sclk_div_d   = 5'b10111;
            rise_cnt_d   = 5'd0;
            first_fall_d = 1'b1;
            tx_shift_d   = {2'b00, chnnl_d, 11'h000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sclk_div_q   <= 5'h1F;
            tx_shift_q   <= 16'h0000;
            rx_shift_q   <= 12'h000;
            rise_cnt_q   <= 5'd0;
            first_fall_q <= 1'b0;
            dead_cnt_q   <= 8'd0;
            chnnl_q      <= 3'd0;
            ss_n_q       <= 1'b1;
            cnv_cmplt_q  <= 1'b0;
            a2d_res_q    <= 12'h000;
        end else begin
            state_q      <= state_d;
            sclk_div_q   <= sclk_div_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            rise_cnt_q   <= rise_cnt_d;
            first_fall_q <= first_fall_d;
            dead_cnt_q   <= dead_cnt_d;
            chnnl_q      <= chnnl_d;
            ss_n_q       <= ss_n_d;
            cnv_cmplt_q  <= cnv_cmplt_d;
            a2d_res_q    <= a2d_res_d;
        end
    end

    assign bus.SS_n      = ss_n_q;
    assign bus.SCLK      = sclk_div_q[4];
    assign bus.MOSI      = tx_shift_q[15];
    assign bus.cnv_cmplt = cnv_cmplt_q;
    assign bus.A2D_res   = a2d_res_q;
endmodule
